// File: rtl/act_unit_pipe_pkg.sv
// act_unit_pipe_pkg: shared activation modes and output-format helpers.
package act_unit_pipe_pkg;
  typedef enum logic [1:0] {BYPASS = 2'd0, RELU = 2'd1, LEAKY = 2'd2, CLIP = 2'd3} act_mode_t;
  function automatic int calc_out_w(input int dw);
    return dw + 4;
  endfunction
  function automatic logic [63:0] sat_max(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction
  function automatic logic [63:0] sat_min(input int w);
    return 64'd1 << (w - 1);
  endfunction
endpackage

// File: rtl/act_unit_pipe_lane.sv
// act_lane: combinational single-lane activation, range check, saturation and clip.
module act_lane
  import act_unit_pipe_pkg::*;
#(
  parameter int DATA_WIDTH       = 16,
  parameter int WEIGHT_INT_WIDTH = 4,
  parameter int LEAK_SHIFT       = 3,
  localparam int XW    = 2 * DATA_WIDTH,
  localparam int OUT_W = calc_out_w(DATA_WIDTH),
  localparam int H     = XW - 2 - WEIGHT_INT_WIDTH
) (
  input  logic signed [XW-1:0]    i_x,
  input  act_mode_t               i_mode,
  input  logic        [OUT_W-2:0] i_clip,
  output logic        [OUT_W-1:0] o_r,
  output logic                    o_sat
);
  logic signed [XW-1:0]    w_shr;
  logic signed [XW-1:0]    w_p;
  logic        [XW-1-H:0]  w_top;
  logic                    w_fit;
  logic        [OUT_W-1:0] w_sr;
  logic                    w_clip;
  logic                    w_unused_lsb;
  assign w_shr = i_x >>> LEAK_SHIFT;
  assign w_p   = (i_mode == BYPASS || !i_x[XW-1]) ? i_x : (i_mode == LEAKY) ? w_shr : '0;
  assign w_top = w_p[XW-1:H];
  assign w_fit = (w_top == '0) || (w_top == '1);
  // Overflow direction follows the sign of the pre-activation value.
  assign w_sr  = w_fit ? w_p[H -: OUT_W] :
                 w_p[XW-1] ? OUT_W'(sat_min(OUT_W)) : OUT_W'(sat_max(OUT_W));
  assign w_clip = (i_mode == CLIP) && (w_sr > {1'b0, i_clip});
  assign o_r    = w_clip ? {1'b0, i_clip} : w_sr;
  assign o_sat  = !w_fit || w_clip;
  assign w_unused_lsb = ^w_p[H-OUT_W:0];
endmodule

// File: rtl/act_unit_pipe.sv
// act_unit_pipe: NUM_CH-lane activation stage, two-register pipeline with saturation counter.
module act_unit_pipe
  import act_unit_pipe_pkg::*;
#(
  parameter int DATA_WIDTH       = 16,
  parameter int WEIGHT_INT_WIDTH = 4,
  parameter int NUM_CH           = 4,
  parameter int LEAK_SHIFT       = 3,
  parameter int CNT_WIDTH        = 16
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic [1:0]                                  mode,
  input  logic [calc_out_w(DATA_WIDTH)-2:0]           clip_val,
  input  logic                                        in_valid,
  output logic                                        in_ready,
  input  logic [NUM_CH*2*DATA_WIDTH-1:0]              in_data,
  output logic                                        out_valid,
  input  logic                                        out_ready,
  output logic [NUM_CH*calc_out_w(DATA_WIDTH)-1:0]    out_data,
  output logic [NUM_CH-1:0]                           out_sat,
  input  logic                                        cnt_clr,
  output logic [CNT_WIDTH-1:0]                        sat_count
);
  localparam int OUT_W = calc_out_w(DATA_WIDTH);
  localparam int XW    = 2 * DATA_WIDTH;
  localparam int SW    = CNT_WIDTH + $clog2(NUM_CH + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  logic [NUM_CH*OUT_W-1:0] w_r;
  logic [NUM_CH-1:0]       w_sat;
  logic                    w_s1_en;
  logic                    w_s2_en;
  logic [SW-1:0]           w_sum;
  logic [CNT_WIDTH-1:0]    w_cnt_nxt;
  logic                    r_s1_valid;
  logic [NUM_CH*OUT_W-1:0] r_s1_data;
  logic [NUM_CH-1:0]       r_s1_sat;
  logic                    r_out_valid;
  logic [NUM_CH*OUT_W-1:0] r_out_data;
  logic [NUM_CH-1:0]       r_out_sat;
  logic [CNT_WIDTH-1:0]    r_cnt;
  for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
    act_lane #(
      .DATA_WIDTH       (DATA_WIDTH),
      .WEIGHT_INT_WIDTH (WEIGHT_INT_WIDTH),
      .LEAK_SHIFT       (LEAK_SHIFT)
    ) u_lane (
      .i_x    (in_data[g*XW +: XW]),
      .i_mode (act_mode_t'(mode)),
      .i_clip (clip_val),
      .o_r    (w_r[g*OUT_W +: OUT_W]),
      .o_sat  (w_sat[g])
    );
  end
  assign w_s2_en  = !r_out_valid || out_ready;
  assign w_s1_en  = !r_s1_valid || w_s2_en;
  assign in_ready = w_s1_en;
  // Widened sum so a carry past the counter width is detected and clamped.
  assign w_sum     = SW'(r_cnt) + SW'($countones(r_s1_sat));
  assign w_cnt_nxt = (w_sum > SW'(CNT_MAX)) ? CNT_MAX : w_sum[CNT_WIDTH-1:0];
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_data   <= '0;
      r_s1_sat    <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sat   <= '0;
      r_cnt       <= '0;
    end else begin
      if (w_s1_en) begin
        r_s1_valid <= in_valid;
        r_s1_data  <= w_r;
        r_s1_sat   <= w_sat;
      end
      if (w_s2_en) begin
        r_out_valid <= r_s1_valid;
        r_out_data  <= r_s1_data;
        r_out_sat   <= r_s1_sat;
      end
      r_cnt <= cnt_clr ? '0 : (w_s2_en && r_s1_valid) ? w_cnt_nxt : r_cnt;
    end
  end
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sat   = r_out_sat;
  assign sat_count = r_cnt;
endmodule
